// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Purpose  : Shared constants and types for the multi-channel PWM block.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Alignment mode encoding, as seen on center_mode and the mode shadow
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Default widths for the counter/duty/period and the prescaler
    localparam int CNT_W_DEF = 8;
    localparam int PRE_W_DEF = 8;

    // Count direction of the up/down counter in centre-aligned mode
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_timebase
//  Purpose  : Prescaler, edge/centre period counter, shadowed period and mode,
//             and the period-boundary strobe shared by all PWM channels.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    input  logic             center_mode,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary,
    output logic             period_tick
);

    logic [PRE_W-1:0] r_pre_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_sh;
    logic             r_mode_sh;
    dir_t             r_dir;
    logic             r_period_tick;

    logic w_tick;
    logic w_at_top;
    logic w_centre;
    logic w_boundary;
    logic w_next_centre;

    // Tick, turnaround and boundary decode from the current shadowed settings.
    // A zero period in centre mode degenerates to edge behaviour.
    always_comb begin
        w_tick        = (r_pre_cnt == prescale);
        w_at_top      = (r_cnt == r_period_sh);
        w_centre      = (r_mode_sh == MODE_CENTER) && (r_period_sh != '0);
        w_boundary    = w_tick && (w_centre ? ((r_dir == DIR_DOWN) && (r_cnt == '0))
                                            : w_at_top);
        // Mode that takes effect at this boundary; centre periods resume at 1
        // so the bottom value is not repeated across the turnaround.
        w_next_centre = (center_mode == MODE_CENTER) && (period != '0);
    end

    // Prescaler, counter, direction and shadow loads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt     <= '0;
            r_cnt         <= '0;
            r_period_sh   <= '0;
            r_mode_sh     <= MODE_EDGE;
            r_dir         <= DIR_UP;
            r_period_tick <= 1'b0;
        end else begin
            r_pre_cnt     <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
            r_period_tick <= w_boundary;
            if (w_boundary) begin
                r_period_sh <= period;
                r_mode_sh   <= center_mode;
                r_dir       <= DIR_UP;
                r_cnt       <= (w_centre && w_next_centre) ? CNT_W'(1) : '0;
            end else if (w_tick) begin
                if (!w_centre) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (r_dir == DIR_UP) begin
                    if (w_at_top) begin
                        r_dir <= DIR_DOWN;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign cnt         = r_cnt;
    assign boundary    = w_boundary;
    assign period_tick = r_period_tick;

endmodule : pwm_timebase
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_channel
//  Purpose  : NUM_CH-output PWM with per-channel double-buffered duty, shared
//             programmable period/prescaler, edge or centre alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PRE_W  = PRE_W_DEF,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm,
    input  logic              duty_we,
    input  logic [ADDR_W-1:0] duty_addr,
    input  logic [CNT_W-1:0]  duty_wdata,
    input  logic [CNT_W-1:0]  period,
    input  logic [PRE_W-1:0]  prescale,
    input  logic              center_mode,
    output logic [NUM_CH-1:0] out,
    output logic              period_tick
);

    logic [CNT_W-1:0]  w_cnt;
    logic              w_boundary;
    logic [NUM_CH-1:0] w_pwm_raw;
    logic [NUM_CH-1:0] r_out;

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .period      (period),
        .prescale    (prescale),
        .center_mode (center_mode),
        .cnt         (w_cnt),
        .boundary    (w_boundary),
        .period_tick (period_tick)
    );

    // Per-channel duty register, shadow and compare. Addresses at or above
    // NUM_CH match no channel, so those writes fall away naturally.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_duty_reg;
        logic [CNT_W-1:0] r_duty_sh;

        // Duty write and boundary load; the shadow takes the pre-write value
        always_ff @(posedge clk) begin
            if (rst) begin
                r_duty_reg <= '0;
                r_duty_sh  <= '0;
            end else begin
                if (duty_we && (duty_addr == ADDR_W'(i))) begin
                    r_duty_reg <= duty_wdata;
                end
                if (w_boundary) begin
                    r_duty_sh <= r_duty_reg;
                end
            end
        end

        assign w_pwm_raw[i] = (w_cnt < r_duty_sh);
    end : g_ch

    // Output mux: disabled -> low, PWM bypassed -> high, else compare result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= en_out & (~en_pwm | w_pwm_raw);
        end
    end

    assign out = r_out;

endmodule : pwm_multi_channel
`default_nettype wire
